m6809_mul_seq: RTL and testbench



---
 rtl/m6809_pkg.sv | 20 ++
 rtl/m6809_mul_step.sv | 28 ++
 rtl/m6809_mul_seq.sv | 106 ++++++++++
 tb/tb_m6809_mul_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/m6809_pkg.sv
// Shared types and constants for the 6809 execute-stage sequencers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package m6809_pkg;

    // MUL sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // One shift-and-add step per multiplier bit.
    localparam int MUL_ITER  = 8;
    localparam int MUL_CNT_W = 4;

    // Counter value during the final RUN step.
    localparam logic [MUL_CNT_W-1:0] MUL_CNT_LAST = MUL_CNT_W'(MUL_ITER - 1);

endpackage

// File: rtl/m6809_mul_step.sv
// One shift-and-add step of the unsigned 8x8 multiply.
// Latency: combinational.
// Backpressure: none; the caller registers the outputs.
//
// Ports:
//   acc, mcand, mplier         - current running product, shifted multiplicand, multiplier
//   acc_nxt, mcand_nxt,
//   mplier_nxt                 - values after this step
//   mplier_zero                - post-shift multiplier is zero (no more partial products)
module m6809_mul_step
    import m6809_pkg::*;
(
    input  logic [15:0] acc,
    input  logic [15:0] mcand,
    input  logic [7:0]  mplier,
    output logic [15:0] acc_nxt,
    output logic [15:0] mcand_nxt,
    output logic [7:0]  mplier_nxt,
    output logic        mplier_zero
);

    // Carry-out of the add is dropped: 0xFF*0xFF = 0xFE01 fits in 16 bits.
    assign acc_nxt     = mplier[0] ? (acc + mcand) : acc;
    assign mcand_nxt   = {mcand[14:0], 1'b0};
    assign mplier_nxt  = {1'b0, mplier[7:1]};
    assign mplier_zero = (mplier_nxt == 8'h00);

endmodule

// File: rtl/m6809_mul_seq.sv
// Multi-cycle sequencer for the 6809 MUL instruction (D = A * B, unsigned 8x8 -> 16, Z and C flags).
// Latency: 9 cycles start-to-done (fewer with M6809_MUL_EARLY_EXIT_EN); one multiply per 10 cycles.
// Backpressure: start is only sampled in IDLE (start & !busy = accepted); start in RUN/DONE is dropped.
//
// Build option: define M6809_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier is zero.
//
// Ports:
//   clk, reset          - core clock, synchronous active-high reset
//   start, a_in, b_in   - request and operands, sampled together in IDLE
//   busy                - high in RUN and DONE
//   done                - one-cycle pulse, result valid from this cycle
//   d_out, z_out, c_out - product, zero flag, carry flag (d_out[7]); held until next completion
module m6809_mul_seq
    import m6809_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] d_out,
    output logic        z_out,
    output logic        c_out
);

    mul_state_t           state;
    logic [15:0]          acc;
    logic [15:0]          mcand;
    logic [7:0]           mplier;
    logic [MUL_CNT_W-1:0] cnt;

    logic [15:0]          acc_nxt;
    logic [15:0]          mcand_nxt;
    logic [7:0]           mplier_nxt;
    logic                 mplier_zero;
    logic                 last_step;

    m6809_mul_step u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_nxt     (acc_nxt),
        .mcand_nxt   (mcand_nxt),
        .mplier_nxt  (mplier_nxt),
        .mplier_zero (mplier_zero)
    );

`ifdef M6809_MUL_EARLY_EXIT_EN
    // Stop once no multiplier bits remain; the counter still caps at 8 steps.
    assign last_step = mplier_zero || (cnt == MUL_CNT_LAST);
`else
    // After the 8th shift the multiplier is always zero, so this is a plain
    // fixed-count exit; qualifying with mplier_zero changes nothing.
    assign last_step = mplier_zero && (cnt == MUL_CNT_LAST);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= 16'h0000;
            mcand  <= 16'h0000;
            mplier <= 8'h00;
            cnt    <= '0;
            d_out  <= 16'h0000;
            z_out  <= 1'b0;
            c_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= 16'h0000;
                        mcand  <= {8'h00, a_in};
                        mplier <= b_in;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + MUL_CNT_W'(1);
                    if (last_step) begin
                        // Flags come from the final product, registered with it.
                        d_out <= acc_nxt;
                        z_out <= (acc_nxt == 16'h0000);
                        c_out <= acc_nxt[7];
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_m6809_mul_seq.sv
// Directed self-checking bench for m6809_mul_seq.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_m6809_mul_seq;
    timeunit 1ns;
    timeprecision 1ps;

`ifdef M6809_MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy;
    logic        done;
    logic [15:0] d_out;
    logic        z_out;
    logic        c_out;

    int total  = 0;
    int passed = 0;

    m6809_mul_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .d_out (d_out),
        .z_out (z_out),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Directed vectors: operands, hand-computed product/flags, done cycle
    // offset from the start cycle in the default and early-exit builds.
    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] d;
        logic        z;
        logic        c;
        int          lat_def;
        int          lat_early;
    } vec_t;

    vec_t vecs[9] = '{
        '{"0c*0a", 8'h0C, 8'h0A, 16'h0078, 1'b0, 1'b0, 9, 5},
        '{"ff*ff", 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 9, 9},
        '{"10*08", 8'h10, 8'h08, 16'h0080, 1'b0, 1'b1, 9, 5},
        '{"00*55", 8'h00, 8'h55, 16'h0000, 1'b1, 1'b0, 9, 8},
        '{"37*00", 8'h37, 8'h00, 16'h0000, 1'b1, 1'b0, 9, 2},
        '{"5a*01", 8'h5A, 8'h01, 16'h005A, 1'b0, 1'b0, 9, 2},
        '{"21*05", 8'h21, 8'h05, 16'h00A5, 1'b0, 1'b1, 9, 4},
        '{"03*80", 8'h03, 8'h80, 16'h0180, 1'b0, 1'b1, 9, 9},
        '{"12*34", 8'h12, 8'h34, 16'h03A8, 1'b0, 1'b1, 9, 7}
    };

    // Issue one multiply from IDLE and follow it to completion.
    task automatic run_mul(input vec_t v);
        int lat;
        int seen;
        int busy_bad;
        lat      = EARLY ? v.lat_early : v.lat_def;
        seen     = 0;
        busy_bad = 0;
        @(negedge clk);
        start = 1'b1; a_in = v.a; b_in = v.b;
        check({v.tag, " busy@T"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        // Operands are don't-care after the sampling edge: scramble them.
        a_in = ~v.a; b_in = v.b ^ 8'h5A;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!busy) busy_bad++;
            if (done) begin
                seen = k;
                check({v.tag, " d_out"}, 32'(d_out), 32'(v.d));
                check({v.tag, " z_out"}, 32'(z_out), 32'(v.z));
                check({v.tag, " c_out"}, 32'(c_out), 32'(v.c));
                break;
            end
        end
        check({v.tag, " done cycle"}, 32'(seen), 32'(lat));
        check({v.tag, " busy low in run"}, 32'(busy_bad), 32'd0);
        @(negedge clk);
        check({v.tag, " idle busy"}, 32'(busy), 32'd0);
        check({v.tag, " done pulse"}, 32'(done), 32'd0);
        check({v.tag, " d_out held"}, 32'(d_out), 32'(v.d));
    endtask

    initial begin
        int ndone;
        int last_k;
        int gap_bad;
        int d_bad;
        int period;
        int exp_cnt;

        reset = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy",  32'(busy),  32'd0);
        check("rst done",  32'(done),  32'd0);
        check("rst d_out", 32'(d_out), 32'd0);
        check("rst z_out", 32'(z_out), 32'd0);
        check("rst c_out", 32'(c_out), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_mul(vecs[i]);

        // Continuous start: one completion per (latency+1) cycles, each 0x0006.
        period  = EARLY ? 4 : 10;
        exp_cnt = EARLY ? 10 : 4;
        ndone = 0; last_k = -1; gap_bad = 0; d_bad = 0;
        @(negedge clk);
        start = 1'b1; a_in = 8'h02; b_in = 8'h03;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                ndone++;
                if (d_out !== 16'h0006) d_bad++;
                if (last_k >= 0 && (k - last_k) != period) gap_bad++;
                last_k = k;
            end
        end
        start = 1'b0;
        check("stream done count", 32'(ndone), 32'(exp_cnt));
        check("stream period", 32'(gap_bad), 32'd0);
        check("stream d_out", 32'(d_bad), 32'd0);
        repeat (12) @(negedge clk);
        check("stream drained", 32'(busy), 32'd0);

        // Reset at T+4 of 0x12*0x34: partial product discarded, no done pulse.
        @(negedge clk);
        start = 1'b1; a_in = 8'h12; b_in = 8'h34;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("midrun busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post-rst busy",  32'(busy),  32'd0);
        check("post-rst d_out", 32'(d_out), 32'd0);
        check("post-rst c_out", 32'(c_out), 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("post-rst no done", 32'(ndone), 32'd0);
        run_mul(vecs[8]);

        // Reset and start in the same cycle: reset wins, start dropped.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; a_in = 8'h0C; b_in = 8'h0A;
        @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst+start busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst+start still idle", 32'(busy), 32'd0);
        check("rst+start d_out", 32'(d_out), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
